// File: rtl/hdmi_bank_packer_if.sv
// ----------------------------------------------------------------------------
// hdmi_bank_packer_if : pixel-stream inputs and Bank write-port outputs
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface hdmi_bank_packer_if #(
  parameter int ADDRESS_DEPTH    = 512,
  parameter int BLOCK_DATA_WIDTH = 32,
  parameter int BLOCK_COUNT      = 4,
  parameter int PIXEL_WIDTH      = 24
);
  localparam int ADDR_W    = $clog2(ADDRESS_DEPTH);
  localparam int BANDWIDTH = BLOCK_COUNT * BLOCK_DATA_WIDTH;

  logic                   frame_start;
  logic                   line_end;
  logic                   pixel_valid;
  logic [PIXEL_WIDTH-1:0] pixel_data;
  logic [ADDR_W-1:0]      ada;
  logic [BANDWIDTH-1:0]   din;
  logic                   cea;
  logic                   oce;
  logic                   overflow;
  logic [ADDR_W:0]        frame_words;

  modport master (
    output frame_start, line_end, pixel_valid, pixel_data,
    input  ada, din, cea, oce, overflow, frame_words
  );

  modport slave (
    input  frame_start, line_end, pixel_valid, pixel_data,
    output ada, din, cea, oce, overflow, frame_words
  );
endinterface

`default_nettype wire

// File: rtl/hdmi_bank_packer.sv
// ----------------------------------------------------------------------------
// hdmi_bank_packer : packs 24-bit pixels into Bank words with per-frame addressing
// Option macro: HDMI_BANK_PACKER_LINE_FLUSH_EN (flush partial word on line_end)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hdmi_bank_packer #(
  parameter int ADDRESS_DEPTH    = 512,
  parameter int BLOCK_DATA_WIDTH = 32,
  parameter int BLOCK_COUNT      = 4,
  parameter int BANDWIDTH        = BLOCK_COUNT * BLOCK_DATA_WIDTH,
  parameter int PIXEL_WIDTH      = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  hdmi_bank_packer_if.slave bus
);
  localparam int ADDR_W = $clog2(ADDRESS_DEPTH);
  localparam int SLOT_W = $clog2(BLOCK_COUNT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_FULL   = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(ADDRESS_DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [SLOT_W-1:0] SLOT_LIMIT = SLOT_W'(BLOCK_COUNT);

  logic [1:0]            r_state;
  logic [SLOT_W-1:0]     r_slot;
  logic [BANDWIDTH-1:0]  r_word;
  logic [ADDR_W-1:0]     r_addr;
  logic [ADDR_W:0]       r_count;
  logic [ADDR_W-1:0]     r_ada;
  logic [BANDWIDTH-1:0]  r_din;
  logic                  r_cea;
  logic                  r_overflow;
  logic [ADDR_W:0]       r_frame_words;

  logic [1:0]                 w_state;
  logic [SLOT_W-1:0]          w_slot;
  logic [BANDWIDTH-1:0]       w_word;
  logic [ADDR_W-1:0]          w_addr;
  logic [ADDR_W:0]            w_count;
  logic [BLOCK_DATA_WIDTH-1:0] w_pix_slot;
  logic                       w_take;
  logic [BANDWIDTH-1:0]       w_packed;
  logic [SLOT_W-1:0]          w_slot_next;
  logic                       w_complete;
  logic                       w_flush;
  logic                       w_commit;

  // frame_start restarts the frame context first, so a pixel in that cycle lands in slot 0
  always_comb begin
    w_state = r_state;
    w_slot  = r_slot;
    w_word  = r_word;
    w_addr  = r_addr;
    w_count = r_count;
    if (bus.frame_start) begin
      w_state = S_ACTIVE;
      w_slot  = '0;
      w_word  = '0;
      w_addr  = '0;
      w_count = '0;
    end

    w_pix_slot                  = '0;
    w_pix_slot[PIXEL_WIDTH-1:0] = bus.pixel_data;
    w_take                      = bus.pixel_valid && (w_state != S_IDLE);

    w_packed = w_word;
    for (int s = 0; s < BLOCK_COUNT; s++) begin
      if (w_take && (w_slot == SLOT_W'(s))) begin
        w_packed[s*BLOCK_DATA_WIDTH +: BLOCK_DATA_WIDTH] = w_pix_slot;
      end
    end

    w_slot_next = w_slot + SLOT_W'(w_take);
    w_complete  = (w_slot_next == SLOT_LIMIT);
  end

`ifdef HDMI_BANK_PACKER_LINE_FLUSH_EN
  assign w_flush = bus.line_end && (w_state != S_IDLE) && (w_slot_next != '0);
`else
  logic w_unused_line_end;
  assign w_unused_line_end = bus.line_end;
  assign w_flush           = 1'b0;
`endif

  assign w_commit = w_complete || w_flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_slot        <= '0;
      r_word        <= '0;
      r_addr        <= '0;
      r_count       <= '0;
      r_ada         <= '0;
      r_din         <= '0;
      r_cea         <= 1'b0;
      r_overflow    <= 1'b0;
      r_frame_words <= '0;
    end else begin
      r_cea   <= 1'b0;
      r_state <= w_state;
      r_addr  <= w_addr;
      r_count <= w_count;

      // r_count already includes any commit issued on the previous edge
      if (bus.frame_start) begin
        r_frame_words <= r_count;
        r_overflow    <= 1'b0;
      end

      if (w_commit) begin
        r_slot <= '0;
        r_word <= '0;
        if (w_state == S_ACTIVE) begin
          r_cea   <= 1'b1;
          r_ada   <= w_addr;
          r_din   <= w_packed;
          r_count <= w_count + COUNT_ONE;
          if (w_addr == LAST_ADDR) begin
            r_state <= S_FULL;
          end else begin
            r_addr <= w_addr + ADDR_ONE;
          end
        end else begin
          r_overflow <= 1'b1;
        end
      end else begin
        r_slot <= w_slot_next;
        r_word <= w_packed;
      end
    end
  end

  assign bus.ada         = r_ada;
  assign bus.din         = r_din;
  assign bus.cea         = r_cea;
  assign bus.oce         = 1'b1;
  assign bus.overflow    = r_overflow;
  assign bus.frame_words = r_frame_words;

endmodule

`default_nettype wire

// File: tb/tb_hdmi_bank_packer.sv
// ----------------------------------------------------------------------------
// tb_hdmi_bank_packer : vector table, corner sequences and randomized model check
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_hdmi_bank_packer;
  localparam int DEPTH = 8;
  localparam int BDW   = 32;
  localparam int BC    = 4;
  localparam int PW    = 24;
  localparam int BW    = BC * BDW;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  hdmi_bank_packer_if #(
    .ADDRESS_DEPTH(DEPTH), .BLOCK_DATA_WIDTH(BDW), .BLOCK_COUNT(BC), .PIXEL_WIDTH(PW)
  ) bus ();

  hdmi_bank_packer #(
    .ADDRESS_DEPTH(DEPTH), .BLOCK_DATA_WIDTH(BDW), .BLOCK_COUNT(BC),
    .BANDWIDTH(BW), .PIXEL_WIDTH(PW)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: frame-level view with a queue of pending pixels
  bit              m_in_frame;
  bit              m_full;
  int              m_words;
  int unsigned     m_pend[$];
  logic            m_cea;
  logic [AW-1:0]   m_ada;
  logic [BW-1:0]   m_din;
  logic            m_ovf;
  logic [AW:0]     m_fw;

  int              cea_seen;
  logic [BW-1:0]   last_din;
  logic [AW-1:0]   last_ada;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_in_frame = 1'b0;
    m_full     = 1'b0;
    m_words    = 0;
    m_pend.delete();
    m_cea      = 1'b0;
    m_ada      = '0;
    m_din      = '0;
    m_ovf      = 1'b0;
    m_fw       = '0;
  endfunction

  function automatic void model_step(input bit fs, input bit le, input bit pv, input logic [PW-1:0] pd);
    bit            flush;
    logic [BW-1:0] w;
    m_cea = 1'b0;
    if (fs) begin
      m_fw       = (AW + 1)'(m_words);
      m_words    = 0;
      m_pend.delete();
      m_ovf      = 1'b0;
      m_in_frame = 1'b1;
      m_full     = 1'b0;
    end
    if (pv && m_in_frame) m_pend.push_back(int'(pd));
    flush = 1'b0;
`ifdef HDMI_BANK_PACKER_LINE_FLUSH_EN
    flush = le && (m_pend.size() > 0);
`else
    if (le) flush = 1'b0;
`endif
    if (m_pend.size() == BC || flush) begin
      w = '0;
      foreach (m_pend[i]) w |= BW'(m_pend[i]) << (i * BDW);
      if (!m_full) begin
        m_cea = 1'b1;
        m_ada = m_words[AW-1:0];
        m_din = w;
        m_words++;
        if (m_words == DEPTH) m_full = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
      m_pend.delete();
    end
  endfunction

  task automatic step(input bit fs, input bit le, input bit pv, input logic [PW-1:0] pd);
    bus.frame_start = fs;
    bus.line_end    = le;
    bus.pixel_valid = pv;
    bus.pixel_data  = pd;
    @(posedge clk);
    model_step(fs, le, pv, pd);
    #1;
    check("cea", BW'(bus.cea), BW'(m_cea));
    check("ada", BW'(bus.ada), BW'(m_ada));
    check("din", bus.din, m_din);
    check("overflow", BW'(bus.overflow), BW'(m_ovf));
    check("frame_words", BW'(bus.frame_words), BW'(m_fw));
    check("oce", BW'(bus.oce), BW'(1'b1));
    if (bus.cea) begin
      cea_seen++;
      last_din = bus.din;
      last_ada = bus.ada;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cea"}, BW'(bus.cea), '0);
    check({tag, "_ada"}, BW'(bus.ada), '0);
    check({tag, "_din"}, bus.din, '0);
    check({tag, "_overflow"}, BW'(bus.overflow), '0);
    check({tag, "_frame_words"}, BW'(bus.frame_words), '0);
    check({tag, "_oce"}, BW'(bus.oce), BW'(1'b1));
  endtask

  // assertion happens between edges so the asynchronous path is exercised
  task automatic do_reset();
    bus.frame_start = 1'b0;
    bus.line_end    = 1'b0;
    bus.pixel_valid = 1'b0;
    bus.pixel_data  = '0;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("rst_async");
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all_zero("rst_hold");
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit          fs;
    bit          le;
    bit          pv;
    logic [23:0] pd;
    bit          e_cea;
    logic [2:0]  e_ada;
    logic [127:0] e_din;
  } vec_t;

  localparam logic [127:0] D1 = 128'h00000004_00000003_00000002_00000001;
  localparam logic [127:0] D2 = 128'h00000008_00000007_00000006_00000005;

  initial begin
    vec_t tbl[9];
    tbl[0] = '{1'b1, 1'b0, 1'b1, 24'h000001, 1'b0, 3'd0, 128'h0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 24'h000002, 1'b0, 3'd0, 128'h0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 24'h000003, 1'b0, 3'd0, 128'h0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 24'h000004, 1'b1, 3'd0, D1};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 24'h000005, 1'b0, 3'd0, D1};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 24'h000006, 1'b0, 3'd0, D1};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 24'h000007, 1'b0, 3'd0, D1};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 24'h000008, 1'b1, 3'd1, D2};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 3'd1, D2};

    reset_n = 1'b1;
    cea_seen = 0;
    last_din = '0;
    last_ada = '0;
    #2;

    // basic packing from the vector table
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].fs, tbl[i].le, tbl[i].pv, tbl[i].pd);
      check("tbl_cea", BW'(bus.cea), BW'(tbl[i].e_cea));
      check("tbl_ada", BW'(bus.ada), BW'(tbl[i].e_ada));
      check("tbl_din", bus.din, tbl[i].e_din);
    end

    // line_end on the 6th pixel
    do_reset();
    cea_seen = 0;
    step(1'b1, 1'b0, 1'b1, 24'h1);
    for (int p = 2; p <= 5; p++) step(1'b0, 1'b0, 1'b1, PW'(p));
    step(1'b0, 1'b1, 1'b1, 24'h6);
    step(1'b0, 1'b0, 1'b0, 24'h0);
    step(1'b0, 1'b0, 1'b0, 24'h0);
`ifdef HDMI_BANK_PACKER_LINE_FLUSH_EN
    check("flush_writes", BW'(cea_seen), BW'(2));
    check("flush_ada", BW'(last_ada), BW'(1));
    check("flush_din", last_din, 128'h00000000_00000000_00000006_00000005);
`else
    check("noflush_writes", BW'(cea_seen), BW'(1));
    check("noflush_ada", BW'(last_ada), BW'(0));
    step(1'b0, 1'b0, 1'b1, 24'h7);
    step(1'b0, 1'b0, 1'b1, 24'h8);
    check("noflush_pending_din", last_din, D2);
    check("noflush_pending_ada", BW'(last_ada), BW'(1));
`endif

    // overflow: 40 pixels into an 8-word bank
    do_reset();
    cea_seen = 0;
    step(1'b1, 1'b0, 1'b1, 24'h1);
    for (int p = 2; p <= 40; p++) step(1'b0, 1'b0, 1'b1, PW'(p));
    step(1'b0, 1'b0, 1'b0, 24'h0);
    check("ovf_writes", BW'(cea_seen), BW'(8));
    check("ovf_last_ada", BW'(last_ada), BW'(7));
    check("ovf_flag", BW'(bus.overflow), BW'(1));
    step(1'b1, 1'b0, 1'b0, 24'h0);
    check("ovf_cleared", BW'(bus.overflow), BW'(0));
    check("ovf_frame_words", BW'(bus.frame_words), BW'(8));

    // frame_start with a pixel discards the partial word
    do_reset();
    step(1'b1, 1'b0, 1'b0, 24'h0);
    for (int p = 1; p <= 3; p++) step(1'b0, 1'b0, 1'b1, PW'(p));
    cea_seen = 0;
    step(1'b1, 1'b0, 1'b1, 24'hAA);
    step(1'b0, 1'b0, 1'b1, 24'hB1);
    step(1'b0, 1'b0, 1'b1, 24'hB2);
    step(1'b0, 1'b0, 1'b1, 24'hB3);
    step(1'b0, 1'b0, 1'b0, 24'h0);
    check("discard_writes", BW'(cea_seen), BW'(1));
    check("discard_ada", BW'(last_ada), BW'(0));
    check("discard_din", last_din, 128'h000000B3_000000B2_000000B1_000000AA);

    // reset mid-word, then pixels without frame_start stay ignored
    do_reset();
    step(1'b1, 1'b0, 1'b1, 24'h11);
    step(1'b0, 1'b0, 1'b1, 24'h22);
    do_reset();
    cea_seen = 0;
    for (int p = 1; p <= 4; p++) step(1'b0, 1'b0, 1'b1, PW'(p));
    step(1'b0, 1'b0, 1'b0, 24'h0);
    check("idle_no_writes", BW'(cea_seen), BW'(0));

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      bit fs, le, pv;
      if ($urandom_range(0, 999) == 0) do_reset();
      fs = ($urandom_range(0, 199) < 3);
      le = ($urandom_range(0, 99) < 8);
      pv = ($urandom_range(0, 99) < 75);
      step(fs, le, pv, PW'($urandom()));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
